traffic_phase_scheduler: RTL and testbench

//  Multi-approach intersection sequencer: arbitrates NUM_PHASES approach requests round-robin.

---
 rtl/traffic_pkg.sv | 15 +
 rtl/traffic_rr_pick.sv | 35 +++
 rtl/traffic_phase_scheduler.sv | 128 ++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types for the intersection phase scheduler.
// Light codes ({R,Y,G}) and the sequencer state encoding.
package traffic_pkg;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  typedef enum logic [1:0] {
    GREEN   = 2'd0,
    YELLOW  = 2'd1,
    ALL_RED = 2'd2
  } sched_state_t;

endpackage

// File: rtl/traffic_rr_pick.sv
// Combinational round-robin picker: first pending index after last.
// Ports: pending, last -> sel (HOME_PHASE when none), any.
module traffic_rr_pick
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int HOME_PHASE = 0
) (
  input  logic [NUM_PHASES-1:0]         pending,
  input  logic [$clog2(NUM_PHASES)-1:0] last,
  output logic [$clog2(NUM_PHASES)-1:0] sel,
  output logic                          any
);

  localparam int PW = $clog2(NUM_PHASES);

  int            idx;
  logic [PW-1:0] idx_l;

  // Walk offsets from farthest to nearest so the nearest hit wins;
  // offset NUM_PHASES wraps back to last itself.
  always_comb begin
    sel   = PW'(HOME_PHASE);
    any   = |pending;
    idx   = 0;
    idx_l = '0;
    for (int k = NUM_PHASES; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= NUM_PHASES) idx = idx - NUM_PHASES;
      idx_l = PW'(idx);
      if (pending[idx_l]) sel = idx_l;
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// N-approach signal sequencer: round-robin GREEN->YELLOW->ALL_RED.
// Ports: clk, rst_n, req -> lights, active_phase, green_valid.
// Optional EMERGENCY_PREEMPT_EN adds emg_req/emg_phase preemption.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES  = 4,
  parameter int HOME_PHASE  = 0,
  parameter int MIN_GREEN   = 20,
  parameter int MAX_GREEN   = 60,
  parameter int YELLOW_TIME = 10,
  parameter int ALLRED_TIME = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PHASES-1:0]         req,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic                          emg_req,
  input  logic [$clog2(NUM_PHASES)-1:0] emg_phase,
`endif
  output logic [3*NUM_PHASES-1:0]       lights,
  output logic [$clog2(NUM_PHASES)-1:0] active_phase,
  output logic                          green_valid
);

  localparam int PW = $clog2(NUM_PHASES);
  localparam int TW = $clog2(MAX_GREEN + 1);

  sched_state_t          state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [NUM_PHASES-1:0] pending_q, pending_d;
  logic [PW-1:0]         active_q, active_d;

  logic [PW-1:0]         pick_sel;
  logic                  pick_any;
  logic [NUM_PHASES-1:0] act_oh;
  logic [NUM_PHASES-1:0] new_oh;
  logic [NUM_PHASES-1:0] set_m;
  logic [NUM_PHASES-1:0] clr_m;
  logic                  others;
  logic                  go;
  logic [PW-1:0]         pick;

  traffic_rr_pick #(
    .NUM_PHASES (NUM_PHASES),
    .HOME_PHASE (HOME_PHASE)
  ) u_pick (
    .pending (pending_q),
    .last    (active_q),
    .sel     (pick_sel),
    .any     (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ALL_RED;
      timer_q   <= '0;
      pending_q <= '0;
      active_q  <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      active_q  <= active_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    act_oh   = NUM_PHASES'(1) << active_q;
    others   = |(pending_q & ~act_oh);
    go       = 1'b0;
    pick     = pick_any ? pick_sel : PW'(HOME_PHASE);
`ifdef EMERGENCY_PREEMPT_EN
    if (emg_req) pick = emg_phase;
`endif
    case (state_q)
      GREEN: begin
        go = (timer_q >= TW'(MIN_GREEN - 1)) && others &&
             (!req[active_q] || timer_q == TW'(MAX_GREEN - 1));
`ifdef EMERGENCY_PREEMPT_EN
        // Preempt ignores MIN_GREEN; the chosen phase holds green.
        if (emg_req) go = (active_q != emg_phase);
`endif
        if (go) state_d = YELLOW;
      end
      YELLOW: begin
        if (timer_q == TW'(YELLOW_TIME - 1)) state_d = ALL_RED;
      end
      ALL_RED: begin
        if (timer_q == TW'(ALLRED_TIME - 1)) begin
          state_d  = GREEN;
          active_d = pick;
        end
      end
      default: state_d = ALL_RED;
    endcase

    // Timer restarts on any state change; green saturates at the cap.
    if (state_d != state_q)
      timer_d = '0;
    else if (state_q == GREEN && timer_q == TW'(MAX_GREEN - 1))
      timer_d = timer_q;
    else
      timer_d = timer_q + TW'(1);

    // Demand is latched except for the phase already green;
    // clearing on green entry wins over a same-cycle set.
    new_oh = NUM_PHASES'(1) << active_d;
    set_m  = req & ~((state_q == GREEN) ? act_oh : '0);
    clr_m  = (state_q == ALL_RED && state_d == GREEN) ? new_oh : '0;
    pending_d = (pending_q | set_m) & ~clr_m;
  end

  always_comb begin
    lights       = {NUM_PHASES{LT_RED}};
    active_phase = active_q;
    green_valid  = (state_q == GREEN);
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (active_q == PW'(i)) begin
        if (state_q == GREEN)  lights[3*i +: 3] = LT_GRN;
        if (state_q == YELLOW) lights[3*i +: 3] = LT_YEL;
      end
    end
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler (N=4 MIN=4 MAX=8 Y=2 AR=1).
// Table-driven timeline plus async-reset and optional preempt sequences.
module tb_traffic_phase_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [11:0] lights;
  logic [1:0]  active_phase;
  logic        green_valid;
`ifdef EMERGENCY_PREEMPT_EN
  logic        emg_req = 1'b0;
  logic [1:0]  emg_phase = '0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  req;
    int          n;
    logic [11:0] lights;
    logic [1:0]  act;
    logic        gv;
  } vec_t;

  vec_t tbl[$];

  traffic_phase_scheduler #(
    .NUM_PHASES  (4),
    .HOME_PHASE  (0),
    .MIN_GREEN   (4),
    .MAX_GREEN   (8),
    .YELLOW_TIME (2),
    .ALLRED_TIME (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
`ifdef EMERGENCY_PREEMPT_EN
    .emg_req      (emg_req),
    .emg_phase    (emg_phase),
`endif
    .lights       (lights),
    .active_phase (active_phase),
    .green_valid  (green_valid)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [11:0] el,
                     input logic [1:0] ea, input logic eg);
    int nonred;
    logic [2:0] g;
    checks++;
    if (lights !== el || active_phase !== ea || green_valid !== eg) begin
      errors++;
      $display("FAIL %s: got lights=%h act=%0d gv=%b, want lights=%h act=%0d gv=%b",
               nm, lights, active_phase, green_valid, el, ea, eg);
    end
    nonred = 0;
    for (int i = 0; i < 4; i++) begin
      g = lights[3*i +: 3];
      if (g !== 3'b100) nonred++;
    end
    checks++;
    if (nonred > 1) begin
      errors++;
      $display("FAIL %s_onegroup: got %0d non-red groups, want <=1", nm, nonred);
    end
  endtask

  initial begin
    // idle rest in home phase
    tbl.push_back('{4'b0000, 50, 12'h921, 2'd0, 1'b1});
    tbl.push_back('{4'b0000, 50, 12'h921, 2'd0, 1'b1});
    // req[2] pulse: 2 yellow, 1 all-red, then phase2
    tbl.push_back('{4'b0100, 1, 12'h921, 2'd0, 1'b1});
    tbl.push_back('{4'b0000, 1, 12'h922, 2'd0, 1'b0});
    tbl.push_back('{4'b0000, 1, 12'h922, 2'd0, 1'b0});
    tbl.push_back('{4'b0000, 1, 12'h924, 2'd0, 1'b0});
    tbl.push_back('{4'b0000, 1, 12'h864, 2'd2, 1'b1});
    tbl.push_back('{4'b0000, 20, 12'h864, 2'd2, 1'b1});
    // move to phase1
    tbl.push_back('{4'b0010, 1, 12'h864, 2'd2, 1'b1});
    tbl.push_back('{4'b0000, 1, 12'h8A4, 2'd2, 1'b0});
    tbl.push_back('{4'b0000, 1, 12'h8A4, 2'd2, 1'b0});
    tbl.push_back('{4'b0000, 1, 12'h924, 2'd2, 1'b0});
    tbl.push_back('{4'b0000, 1, 12'h90C, 2'd1, 1'b1});
    // phase1 green, pending {0,2,3}: order 2,3,0 after min green
    tbl.push_back('{4'b1101, 1, 12'h90C, 2'd1, 1'b1});
    tbl.push_back('{4'b0000, 2, 12'h90C, 2'd1, 1'b1});
    tbl.push_back('{4'b0000, 1, 12'h914, 2'd1, 1'b0});
    tbl.push_back('{4'b0000, 1, 12'h914, 2'd1, 1'b0});
    tbl.push_back('{4'b0000, 1, 12'h924, 2'd1, 1'b0});
    tbl.push_back('{4'b0000, 1, 12'h864, 2'd2, 1'b1});
    tbl.push_back('{4'b0000, 3, 12'h864, 2'd2, 1'b1});
    tbl.push_back('{4'b0000, 1, 12'h8A4, 2'd2, 1'b0});
    tbl.push_back('{4'b0000, 1, 12'h8A4, 2'd2, 1'b0});
    tbl.push_back('{4'b0000, 1, 12'h924, 2'd2, 1'b0});
    tbl.push_back('{4'b0000, 1, 12'h324, 2'd3, 1'b1});
    tbl.push_back('{4'b0000, 3, 12'h324, 2'd3, 1'b1});
    tbl.push_back('{4'b0000, 1, 12'h524, 2'd3, 1'b0});
    tbl.push_back('{4'b0000, 1, 12'h524, 2'd3, 1'b0});
    tbl.push_back('{4'b0000, 1, 12'h924, 2'd3, 1'b0});
    tbl.push_back('{4'b0000, 1, 12'h921, 2'd0, 1'b1});
    tbl.push_back('{4'b0000, 20, 12'h921, 2'd0, 1'b1});
    // via phase3 back to a fresh phase0 green with req[0] held
    tbl.push_back('{4'b1000, 1, 12'h921, 2'd0, 1'b1});
    tbl.push_back('{4'b0001, 1, 12'h922, 2'd0, 1'b0});
    tbl.push_back('{4'b0001, 1, 12'h922, 2'd0, 1'b0});
    tbl.push_back('{4'b0001, 1, 12'h924, 2'd0, 1'b0});
    tbl.push_back('{4'b0001, 1, 12'h324, 2'd3, 1'b1});
    tbl.push_back('{4'b0001, 3, 12'h324, 2'd3, 1'b1});
    tbl.push_back('{4'b0001, 1, 12'h524, 2'd3, 1'b0});
    tbl.push_back('{4'b0001, 1, 12'h524, 2'd3, 1'b0});
    tbl.push_back('{4'b0001, 1, 12'h924, 2'd3, 1'b0});
    tbl.push_back('{4'b0001, 1, 12'h921, 2'd0, 1'b1});
    // req[1] pulse at green cycle 0: yield only at MAX_GREEN
    tbl.push_back('{4'b0011, 1, 12'h921, 2'd0, 1'b1});
    tbl.push_back('{4'b0001, 5, 12'h921, 2'd0, 1'b1});
    tbl.push_back('{4'b0001, 1, 12'h921, 2'd0, 1'b1});
    tbl.push_back('{4'b0001, 1, 12'h922, 2'd0, 1'b0});
    tbl.push_back('{4'b0000, 1, 12'h922, 2'd0, 1'b0});
    tbl.push_back('{4'b0000, 1, 12'h924, 2'd0, 1'b0});
    tbl.push_back('{4'b0000, 1, 12'h90C, 2'd1, 1'b1});
    tbl.push_back('{4'b0000, 10, 12'h90C, 2'd1, 1'b1});
    // req for the green phase itself must not latch
    tbl.push_back('{4'b0010, 1, 12'h90C, 2'd1, 1'b1});
    tbl.push_back('{4'b0000, 10, 12'h90C, 2'd1, 1'b1});
    tbl.push_back('{4'b1000, 1, 12'h90C, 2'd1, 1'b1});
    tbl.push_back('{4'b0000, 1, 12'h914, 2'd1, 1'b0});
    tbl.push_back('{4'b0000, 1, 12'h914, 2'd1, 1'b0});
    tbl.push_back('{4'b0000, 1, 12'h924, 2'd1, 1'b0});
    tbl.push_back('{4'b0000, 1, 12'h324, 2'd3, 1'b1});
    tbl.push_back('{4'b0000, 10, 12'h324, 2'd3, 1'b1});

    #12;
    chk("reset", 12'h924, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("first_allred", 12'h924, 2'd0, 1'b0);
    step(1);
    chk("home_green", 12'h921, 2'd0, 1'b1);

    for (int i = 0; i < tbl.size(); i++) begin
      req = tbl[i].req;
      step(tbl[i].n);
      chk($sformatf("vec%0d", i), tbl[i].lights, tbl[i].act, tbl[i].gv);
    end

    // async reset mid-yellow drops pending demand
    req = 4'b0110;
    step(1);
    chk("pre_rst", 12'h324, 2'd3, 1'b1);
    req = 4'b0000;
    step(1);
    chk("pre_rst_yel", 12'h524, 2'd3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", 12'h924, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release", 12'h924, 2'd0, 1'b0);
    step(1);
    chk("rst_home", 12'h921, 2'd0, 1'b1);
    step(20);
    chk("pending_lost", 12'h921, 2'd0, 1'b1);

`ifdef EMERGENCY_PREEMPT_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    chk("emg_home", 12'h921, 2'd0, 1'b1);
    req = 4'b0010;
    step(1);
    chk("emg_pre", 12'h921, 2'd0, 1'b1);
    req = 4'b0000;
    emg_req = 1'b1;
    emg_phase = 2'd3;
    step(1);
    chk("emg_yel0", 12'h922, 2'd0, 1'b0);
    step(1);
    chk("emg_yel1", 12'h922, 2'd0, 1'b0);
    step(1);
    chk("emg_ar", 12'h924, 2'd0, 1'b0);
    step(1);
    chk("emg_grn", 12'h324, 2'd3, 1'b1);
    step(10);
    chk("emg_hold", 12'h324, 2'd3, 1'b1);
    emg_req = 1'b0;
    step(1);
    chk("emg_rel_yel", 12'h524, 2'd3, 1'b0);
    step(1);
    chk("emg_rel_yel1", 12'h524, 2'd3, 1'b0);
    step(1);
    chk("emg_rel_ar", 12'h924, 2'd3, 1'b0);
    step(1);
    chk("emg_served1", 12'h90C, 2'd1, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
